umi_sim_queue_pair: RTL and testbench
=====================================

Name: umi_sim_queue_pair

Overview:
Synthesizable stand-in for the simulation UMI RX/TX endpoints (the umi_rx_sim/umi_tx_sim pair). A host-side push interface feeds an RX FIFO that drives a 256-bit valid/ready UMI packet stream into the design. A TX FIFO accepts the design's 256-bit UMI packet stream and drains it through a host-side pop interface. It sits between the test host (queue driver) and the UMI datapath under test; the port-name string binding of the simulation models is replaced by the fixed host interfaces.

Parameters:
DW, 256, UMI packet width in bits (multiple of 32)
DEPTH, 4, entries per FIFO (power of two, >=2)
CW, $clog2(DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  input  1  single clock, all logic rising-edge
nreset  input  1  asynchronous active-low reset
host_wr_valid  input  1  host offers packet for RX FIFO
host_wr_data  input  DW  host packet
host_wr_ready  output  1  RX FIFO can accept (not full)
rx_packet  output  DW  head packet of RX FIFO toward design
rx_valid  output  1  RX FIFO non-empty
rx_ready  input  1  design accepts rx_packet
tx_packet  input  DW  packet from design
tx_valid  input  1  design offers tx_packet
tx_ready  output  1  TX FIFO can accept (not full)
host_rd_data  output  DW  head packet of TX FIFO toward host
host_rd_valid  output  1  TX FIFO non-empty
host_rd_ready  input  1  host pops
rx_count  output  CW  RX FIFO occupancy
tx_count  output  CW  TX FIFO occupancy

Behaviour:
- Reset (nreset low, async): all pointers and counts are 0, rx_valid=0, host_rd_valid=0, host_wr_ready=1, tx_ready=1, rx_packet=0, host_rd_data=0. Deassertion takes effect at the next rising edge. Reset mid-transfer discards all stored packets.
- Transfer rule (both sides): a beat moves on a rising edge when valid&&ready. Valid must not depend combinationally on ready; ready is a function of FIFO state only.
- Push side: ready = (count != DEPTH). Push and pop in the same cycle with count==DEPTH: the pop completes, the push is refused because ready was already low. This keeps push-ready free of combinational paths.
- Pop side: valid = (count != 0). Data = mem[rd_ptr] when valid, else forced to all-zero.
- Latency: a packet pushed on edge N appears on the output with valid high after edge N (visible in cycle N+1). There is no bypass when empty.
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is CW bits and saturates at DEPTH by construction.
- Ordering is strictly FIFO. Packets are bit-exact, with no modification inside this block.
- RX and TX FIFOs are fully independent; activity on one never stalls the other.
- Memory array is not reset; the zero-forcing on outputs hides its contents.

Decomposition:
- Package umi_sim_pkg: DW default constant, and typedef umi_packet_t = logic [DW-1:0].
- One sub-module, umi_sim_fifo (parameters DW, DEPTH; in_valid/in_data/in_ready, out_valid/out_data/out_ready, count).
- The top instantiates umi_sim_fifo twice (RX and TX) plus wiring.

Test Plan:
- Reset check: assert nreset=0 mid-run with 3 packets queued -> immediately rx_valid=0, rx_packet=0, rx_count=0, host_wr_ready=1, tx_ready=1.
- Loopback +1: bench connects rx_packet to tx_packet, with each 32-bit word +1, and wires valid/ready through. Push words 0x00000007 (all 8 lanes) -> host_rd_data lanes = 0x00000008. Push lane value 0xFFFFFFFF -> lane reads 0x00000000, with no carry into the adjacent lane.
- Full RX: hold rx_ready=0 and push 5 packets with DEPTH=4 -> host_wr_ready drops after 4th accept, rx_count=4. Raise rx_ready for one cycle -> count 3, host_wr_ready=1 the next cycle, and the 5th packet is then accepted.
- Simultaneous push/pop at count=2 -> count stays 2, order preserved. Push A,B,C,D then pop four -> A,B,C,D exactly.
- Backpressure TX: tx_valid continuous with host_rd_ready=0 -> tx_ready low after 4 beats. Pop one -> exactly one more beat is accepted, and no beat is lost or duplicated.
- Independence: RX full and stalled while TX streams 8 packets with host_rd_ready=1 -> all 8 delivered in order, and rx_count holds 4.

Source files
------------

// File: rtl/umi_sim_queue_pair_pkg.sv
// ---------------------------------------------------------------------------
// umi_sim_pkg
// Shared constants and types for the UMI queue-pair endpoint stand-in.
//   UMI_DW       default UMI packet width in bits (multiple of 32)
//   UMI_DEPTH    default entries per FIFO
//   UMI_LANE_W   width of one 32-bit lane inside a packet
//   umi_packet_t one full-width UMI packet at the default width
// ---------------------------------------------------------------------------
package umi_sim_pkg;

  localparam int UMI_DW     = 256;
  localparam int UMI_DEPTH  = 4;
  localparam int UMI_LANE_W = 32;

  typedef logic [UMI_DW-1:0] umi_packet_t;

endpackage : umi_sim_pkg

// File: rtl/umi_sim_queue_pair_if.sv
// ---------------------------------------------------------------------------
// umi_sim_queue_pair_if
// Host and design facing handshake bundle of the queue pair.
//   host_wr_*      host pushes packets into the RX FIFO
//   rx_*           RX FIFO head streamed toward the design
//   tx_*           design streams packets into the TX FIFO
//   host_rd_*      host pops packets from the TX FIFO
//   rx/tx_count    FIFO occupancies
// Modports: master = host/design side, slave = the queue pair.
// ---------------------------------------------------------------------------
interface umi_sim_queue_pair_if
  import umi_sim_pkg::*;
#(
  parameter int DW    = UMI_DW,
  parameter int DEPTH = UMI_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          host_wr_valid;
  logic [DW-1:0] host_wr_data;
  logic          host_wr_ready;
  logic [DW-1:0] rx_packet;
  logic          rx_valid;
  logic          rx_ready;
  logic [DW-1:0] tx_packet;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] host_rd_data;
  logic          host_rd_valid;
  logic          host_rd_ready;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;

  modport master (
    output host_wr_valid, host_wr_data, rx_ready, tx_packet, tx_valid, host_rd_ready,
    input  host_wr_ready, rx_packet, rx_valid, tx_ready, host_rd_data, host_rd_valid,
           rx_count, tx_count
  );

  modport slave (
    input  host_wr_valid, host_wr_data, rx_ready, tx_packet, tx_valid, host_rd_ready,
    output host_wr_ready, rx_packet, rx_valid, tx_ready, host_rd_data, host_rd_valid,
           rx_count, tx_count
  );

endinterface : umi_sim_queue_pair_if

// File: rtl/umi_sim_queue_pair_fifo.sv
// ---------------------------------------------------------------------------
// umi_sim_fifo
// Single-clock valid/ready FIFO without bypass.
//   clk, nreset                 clock, async active-low reset
//   in_valid/in_data/in_ready   write side; ready depends only on occupancy
//   out_valid/out_data/out_ready read side; data forced to zero when empty
//   count                       occupancy, 0..DEPTH
// A push into a full FIFO is refused even when a pop happens on the same
// edge, so in_ready never has a combinational path from out_ready.
// ---------------------------------------------------------------------------
module umi_sim_fifo
  import umi_sim_pkg::*;
#(
  parameter int DW    = UMI_DW,
  parameter int DEPTH = UMI_DEPTH
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH naturally.
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; out_data is zero-forced while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule : umi_sim_fifo

// File: rtl/umi_sim_queue_pair.sv
// ---------------------------------------------------------------------------
// umi_sim_queue_pair
// Synthesizable replacement for the simulation UMI RX/TX endpoint pair.
//   clk, nreset  clock, async active-low reset
//   bus (slave)  host push -> RX FIFO -> rx_* stream toward the design;
//                design tx_* stream -> TX FIFO -> host pop
// The two FIFOs share nothing but clock and reset.
// ---------------------------------------------------------------------------
module umi_sim_queue_pair
  import umi_sim_pkg::*;
#(
  parameter int DW    = UMI_DW,
  parameter int DEPTH = UMI_DEPTH
) (
  input  logic                 clk,
  input  logic                 nreset,
  umi_sim_queue_pair_if.slave  bus
);

  umi_sim_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (bus.host_wr_valid),
    .in_data   (bus.host_wr_data),
    .in_ready  (bus.host_wr_ready),
    .out_valid (bus.rx_valid),
    .out_data  (bus.rx_packet),
    .out_ready (bus.rx_ready),
    .count     (bus.rx_count)
  );

  umi_sim_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (bus.tx_valid),
    .in_data   (bus.tx_packet),
    .in_ready  (bus.tx_ready),
    .out_valid (bus.host_rd_valid),
    .out_data  (bus.host_rd_data),
    .out_ready (bus.host_rd_ready),
    .count     (bus.tx_count)
  );

endmodule : umi_sim_queue_pair

// File: tb/tb_umi_sim_queue_pair.sv
// ---------------------------------------------------------------------------
// tb_umi_sim_queue_pair
// Self-checking bench for umi_sim_queue_pair. The reference model keeps one
// SystemVerilog queue per FIFO; transfers follow the valid&&ready rule with
// ready = not full and valid = not empty.
// ---------------------------------------------------------------------------
module tb_umi_sim_queue_pair;
  import umi_sim_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LANES = UMI_DW / UMI_LANE_W;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  // Bench-driven stimulus
  logic        h_wr_valid, d_rx_ready, d_tx_valid, h_rd_ready, loop_en;
  umi_packet_t h_wr_data, d_tx_packet;

  umi_sim_queue_pair_if #(.DW(UMI_DW), .DEPTH(DEPTH)) bus ();

  // Loopback mode wires the design side back to itself with each lane +1.
  assign bus.host_wr_valid = h_wr_valid;
  assign bus.host_wr_data  = h_wr_data;
  assign bus.host_rd_ready = h_rd_ready;
  assign bus.rx_ready      = loop_en ? bus.tx_ready : d_rx_ready;
  assign bus.tx_valid      = loop_en ? bus.rx_valid : d_tx_valid;
  assign bus.tx_packet     = loop_en ? plus1(bus.rx_packet) : d_tx_packet;

  umi_sim_queue_pair #(.DW(UMI_DW), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // Reference model
  umi_packet_t rxq[$];
  umi_packet_t txq[$];
  bit          rx_pushed, tx_pushed;
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic umi_packet_t plus1(umi_packet_t p);
    umi_packet_t r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = p[i*32 +: 32] + 32'd1;
    return r;
  endfunction

  function automatic umi_packet_t rand_pkt();
    umi_packet_t r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Advance one clock; the model decides transfers from pre-edge state.
  task automatic tick();
    bit          rx_pop, tx_push, tx_pop;
    umi_packet_t tx_val;
    rx_pushed = h_wr_valid && (rxq.size() < DEPTH);
    if (loop_en) begin
      rx_pop  = (rxq.size() > 0) && (txq.size() < DEPTH);
      tx_push = rx_pop;
      tx_val  = rx_pop ? plus1(rxq[0]) : '0;
    end else begin
      rx_pop  = d_rx_ready && (rxq.size() > 0);
      tx_push = d_tx_valid && (txq.size() < DEPTH);
      tx_val  = d_tx_packet;
    end
    tx_pop = h_rd_ready && (txq.size() > 0);
    @(posedge clk);
    #1;
    if (rx_pop)    void'(rxq.pop_front());
    if (rx_pushed) rxq.push_back(h_wr_data);
    if (tx_pop)    void'(txq.pop_front());
    if (tx_push)   txq.push_back(tx_val);
    tx_pushed = tx_push;
  endtask

  task automatic idle_inputs();
    h_wr_valid = 1'b0; d_rx_ready = 1'b0; d_tx_valid = 1'b0; h_rd_ready = 1'b0;
    h_wr_data  = '0;   d_tx_packet = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    loop_en = 1'b0;
    nreset  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); else n_pass++;
    n_total++; if (bus.host_rd_valid !== 1'b0) $display("FAIL reset_host_rd_valid got=%b exp=0", bus.host_rd_valid); else n_pass++;
    n_total++; if (bus.host_wr_ready !== 1'b1) $display("FAIL reset_host_wr_ready got=%b exp=1", bus.host_wr_ready); else n_pass++;
    n_total++; if (bus.tx_ready !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); else n_pass++;
    n_total++; if (bus.rx_packet !== '0) $display("FAIL reset_rx_packet got=%h exp=0", bus.rx_packet); else n_pass++;
    n_total++; if (bus.host_rd_data !== '0) $display("FAIL reset_host_rd_data got=%h exp=0", bus.host_rd_data); else n_pass++;
    n_total++; if (bus.rx_count !== CW'(0)) $display("FAIL reset_rx_count got=%0d exp=0", bus.rx_count); else n_pass++;
    n_total++; if (bus.tx_count !== CW'(0)) $display("FAIL reset_tx_count got=%0d exp=0", bus.tx_count); else n_pass++;
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_loopback();
    umi_packet_t pkt, exp;
    idle_inputs();
    loop_en = 1'b1;
    // All lanes 7 -> all lanes 8
    h_wr_valid = 1'b1; h_wr_data = {LANES{32'h0000_0007}};
    tick();
    h_wr_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.host_rd_valid; i++) tick();
    n_total++; if (bus.host_rd_valid !== 1'b1) $display("FAIL loop7_timeout got=%b exp=1", bus.host_rd_valid); else n_pass++;
    exp = {LANES{32'h0000_0008}};
    n_total++; if (bus.host_rd_data !== exp) $display("FAIL loop7_data got=%h exp=%h", bus.host_rd_data, exp); else n_pass++;
    h_rd_ready = 1'b1; tick(); h_rd_ready = 1'b0;
    // Lane wrap without carry into the neighbouring lane
    pkt = {LANES{32'hFFFF_FFFE}};
    pkt[31:0] = 32'hFFFF_FFFF; pkt[63:32] = 32'h1234_5678;
    exp = {LANES{32'hFFFF_FFFF}};
    exp[31:0] = 32'h0000_0000; exp[63:32] = 32'h1234_5679;
    h_wr_valid = 1'b1; h_wr_data = pkt;
    tick();
    h_wr_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.host_rd_valid; i++) tick();
    n_total++; if (bus.host_rd_valid !== 1'b1) $display("FAIL loopwrap_timeout got=%b exp=1", bus.host_rd_valid); else n_pass++;
    n_total++; if (bus.host_rd_data !== exp) $display("FAIL loopwrap_data got=%h exp=%h", bus.host_rd_data, exp); else n_pass++;
    h_rd_ready = 1'b1; tick(); h_rd_ready = 1'b0;
    // Random loopback stream compared against the model every cycle
    for (int c = 0; c < 60; c++) begin
      h_wr_valid = 1'($urandom_range(0, 1));
      h_wr_data  = rand_pkt();
      h_rd_ready = 1'($urandom_range(0, 1));
      tick();
      exp = (txq.size() > 0) ? txq[0] : '0;
      n_total++; if (bus.host_rd_data !== exp) $display("FAIL loop_rand_data cyc=%0d got=%h exp=%h", c, bus.host_rd_data, exp); else n_pass++;
      n_total++; if (bus.host_rd_valid !== (txq.size() > 0)) $display("FAIL loop_rand_valid cyc=%0d got=%b", c, bus.host_rd_valid); else n_pass++;
    end
    h_wr_valid = 1'b0; h_rd_ready = 1'b1;
    repeat (12) tick();
    n_total++; if (bus.tx_count !== CW'(0) || bus.rx_count !== CW'(0)) $display("FAIL loop_drain got rx=%0d tx=%0d exp=0/0", bus.rx_count, bus.tx_count); else n_pass++;
    idle_inputs();
    loop_en = 1'b0;
  endtask

  task automatic test_full_rx();
    umi_packet_t pkts[5];
    int k = 0;
    idle_inputs();
    foreach (pkts[i]) pkts[i] = rand_pkt();
    h_wr_valid = 1'b1; h_wr_data = pkts[0];
    for (int c = 0; c < 10 && k < 4; c++) begin
      tick();
      if (rx_pushed) k++;
      h_wr_data = pkts[k];
    end
    n_total++; if (bus.host_wr_ready !== 1'b0) $display("FAIL full_wr_ready got=%b exp=0", bus.host_wr_ready); else n_pass++;
    n_total++; if (bus.rx_count !== CW'(4)) $display("FAIL full_count got=%0d exp=4", bus.rx_count); else n_pass++;
    tick();  // push held while full must be refused
    n_total++; if (bus.rx_count !== CW'(4)) $display("FAIL full_refused got=%0d exp=4", bus.rx_count); else n_pass++;
    d_rx_ready = 1'b1; tick(); d_rx_ready = 1'b0;  // pop while full: push still refused
    n_total++; if (bus.rx_count !== CW'(3)) $display("FAIL full_pop_count got=%0d exp=3", bus.rx_count); else n_pass++;
    n_total++; if (bus.host_wr_ready !== 1'b1) $display("FAIL full_pop_ready got=%b exp=1", bus.host_wr_ready); else n_pass++;
    n_total++; if (bus.rx_packet !== pkts[1]) $display("FAIL full_pop_head got=%h exp=%h", bus.rx_packet, pkts[1]); else n_pass++;
    tick();  // 5th packet accepted now
    h_wr_valid = 1'b0;
    n_total++; if (bus.rx_count !== CW'(4)) $display("FAIL full_fifth_count got=%0d exp=4", bus.rx_count); else n_pass++;
    d_rx_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_total++; if (bus.rx_packet !== pkts[i]) $display("FAIL full_drain_%0d got=%h exp=%h", i, bus.rx_packet, pkts[i]); else n_pass++;
      tick();
    end
    n_total++; if (bus.rx_valid !== 1'b0 || bus.rx_packet !== '0) $display("FAIL full_empty got v=%b d=%h exp 0/0", bus.rx_valid, bus.rx_packet); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    umi_packet_t p[4];
    idle_inputs();
    foreach (p[i]) p[i] = rand_pkt();
    h_wr_valid = 1'b1;
    h_wr_data = p[0]; tick();
    h_wr_data = p[1]; tick();
    h_wr_data = p[2]; d_rx_ready = 1'b1; tick();
    n_total++; if (bus.rx_count !== CW'(2)) $display("FAIL simul_count1 got=%0d exp=2", bus.rx_count); else n_pass++;
    n_total++; if (bus.rx_packet !== p[1]) $display("FAIL simul_head1 got=%h exp=%h", bus.rx_packet, p[1]); else n_pass++;
    h_wr_data = p[3]; tick();
    n_total++; if (bus.rx_count !== CW'(2)) $display("FAIL simul_count2 got=%0d exp=2", bus.rx_count); else n_pass++;
    n_total++; if (bus.rx_packet !== p[2]) $display("FAIL simul_head2 got=%h exp=%h", bus.rx_packet, p[2]); else n_pass++;
    h_wr_valid = 1'b0;
    tick();
    n_total++; if (bus.rx_packet !== p[3]) $display("FAIL simul_head3 got=%h exp=%h", bus.rx_packet, p[3]); else n_pass++;
    tick();
    d_rx_ready = 1'b0;
    // Fill four, then pop four in order
    h_wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin h_wr_data = p[i]; tick(); end
    h_wr_valid = 1'b0;
    n_total++; if (bus.rx_count !== CW'(4)) $display("FAIL order_fill got=%0d exp=4", bus.rx_count); else n_pass++;
    d_rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (bus.rx_packet !== p[i]) $display("FAIL order_pop_%0d got=%h exp=%h", i, bus.rx_packet, p[i]); else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_tx_backpressure();
    umi_packet_t seq[6];
    int k = 0;
    idle_inputs();
    foreach (seq[i]) seq[i] = rand_pkt();
    d_tx_valid = 1'b1; d_tx_packet = seq[0];
    for (int c = 0; c < 8; c++) begin
      tick();
      if (tx_pushed) k++;
      d_tx_packet = seq[k];
    end
    n_total++; if (k != 4 || bus.tx_ready !== 1'b0) $display("FAIL bp_full got beats=%0d ready=%b exp 4/0", k, bus.tx_ready); else n_pass++;
    n_total++; if (bus.tx_count !== CW'(4)) $display("FAIL bp_count got=%0d exp=4", bus.tx_count); else n_pass++;
    h_rd_ready = 1'b1; tick(); h_rd_ready = 1'b0;
    n_total++; if (bus.tx_count !== CW'(3) || bus.tx_ready !== 1'b1) $display("FAIL bp_pop got cnt=%0d ready=%b exp 3/1", bus.tx_count, bus.tx_ready); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (tx_pushed) k++;
      d_tx_packet = seq[k];
    end
    d_tx_valid = 1'b0;
    n_total++; if (k != 5 || bus.tx_count !== CW'(4)) $display("FAIL bp_one_more got beats=%0d cnt=%0d exp 5/4", k, bus.tx_count); else n_pass++;
    h_rd_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      n_total++; if (bus.host_rd_data !== seq[i]) $display("FAIL bp_drain_%0d got=%h exp=%h", i, bus.host_rd_data, seq[i]); else n_pass++;
      tick();
    end
    n_total++; if (bus.host_rd_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", bus.host_rd_valid); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_independence();
    umi_packet_t seq[8];
    umi_packet_t recv[$];
    int k = 0;
    idle_inputs();
    foreach (seq[i]) seq[i] = rand_pkt();
    h_wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin h_wr_data = rand_pkt(); tick(); end
    h_rd_ready = 1'b1;
    for (int c = 0; c < 60 && recv.size() < 8; c++) begin
      d_tx_valid  = (k < 8) && ($urandom_range(0, 3) != 0);
      d_tx_packet = (k < 8) ? seq[k] : '0;
      if (bus.host_rd_valid) recv.push_back(bus.host_rd_data);
      tick();
      if (tx_pushed) k++;
    end
    d_tx_valid = 1'b0;
    n_total++; if (recv.size() != 8) $display("FAIL indep_delivered got=%0d exp=8", recv.size()); else n_pass++;
    for (int i = 0; i < 8 && i < recv.size(); i++) begin
      n_total++; if (recv[i] !== seq[i]) $display("FAIL indep_pkt_%0d got=%h exp=%h", i, recv[i], seq[i]); else n_pass++;
    end
    n_total++; if (bus.rx_count !== CW'(4) || bus.host_wr_ready !== 1'b0) $display("FAIL indep_rx_hold got cnt=%0d ready=%b exp 4/0", bus.rx_count, bus.host_wr_ready); else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    umi_packet_t exp_rx, exp_tx;
    for (int c = 0; c < 300; c++) begin
      h_wr_valid  = 1'($urandom_range(0, 1)); h_wr_data   = rand_pkt();
      d_rx_ready  = 1'($urandom_range(0, 1));
      d_tx_valid  = 1'($urandom_range(0, 1)); d_tx_packet = rand_pkt();
      h_rd_ready  = 1'($urandom_range(0, 1));
      tick();
      exp_rx = (rxq.size() > 0) ? rxq[0] : '0;
      exp_tx = (txq.size() > 0) ? txq[0] : '0;
      n_total++; if (bus.rx_packet !== exp_rx) $display("FAIL rand_rx_packet cyc=%0d got=%h exp=%h", c, bus.rx_packet, exp_rx); else n_pass++;
      n_total++; if (bus.rx_valid !== (rxq.size() != 0)) $display("FAIL rand_rx_valid cyc=%0d got=%b", c, bus.rx_valid); else n_pass++;
      n_total++; if (bus.rx_count !== CW'(rxq.size())) $display("FAIL rand_rx_count cyc=%0d got=%0d exp=%0d", c, bus.rx_count, rxq.size()); else n_pass++;
      n_total++; if (bus.host_wr_ready !== (rxq.size() != DEPTH)) $display("FAIL rand_wr_ready cyc=%0d got=%b", c, bus.host_wr_ready); else n_pass++;
      n_total++; if (bus.host_rd_data !== exp_tx) $display("FAIL rand_rd_data cyc=%0d got=%h exp=%h", c, bus.host_rd_data, exp_tx); else n_pass++;
      n_total++; if (bus.host_rd_valid !== (txq.size() != 0)) $display("FAIL rand_rd_valid cyc=%0d got=%b", c, bus.host_rd_valid); else n_pass++;
      n_total++; if (bus.tx_count !== CW'(txq.size())) $display("FAIL rand_tx_count cyc=%0d got=%0d exp=%0d", c, bus.tx_count, txq.size()); else n_pass++;
      n_total++; if (bus.tx_ready !== (txq.size() != DEPTH)) $display("FAIL rand_tx_ready cyc=%0d got=%b", c, bus.tx_ready); else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    while (rxq.size() > 0) begin d_rx_ready = 1'b1; tick(); end
    d_rx_ready = 1'b0;
    h_wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin h_wr_data = rand_pkt(); tick(); end
    h_wr_valid = 1'b0;
    n_total++; if (bus.rx_count !== CW'(3)) $display("FAIL mid_prefill got=%0d exp=3", bus.rx_count); else n_pass++;
    #2 nreset = 1'b0;
    #1;
    rxq.delete(); txq.delete();
    n_total++; if (bus.rx_valid !== 1'b0) $display("FAIL mid_rx_valid got=%b exp=0", bus.rx_valid); else n_pass++;
    n_total++; if (bus.rx_packet !== '0) $display("FAIL mid_rx_packet got=%h exp=0", bus.rx_packet); else n_pass++;
    n_total++; if (bus.rx_count !== CW'(0)) $display("FAIL mid_rx_count got=%0d exp=0", bus.rx_count); else n_pass++;
    n_total++; if (bus.host_wr_ready !== 1'b1) $display("FAIL mid_wr_ready got=%b exp=1", bus.host_wr_ready); else n_pass++;
    n_total++; if (bus.tx_ready !== 1'b1) $display("FAIL mid_tx_ready got=%b exp=1", bus.tx_ready); else n_pass++;
    @(negedge clk);
    nreset = 1'b1;
    tick();
    n_total++; if (bus.rx_valid !== 1'b0 || bus.rx_count !== CW'(0)) $display("FAIL mid_after got v=%b cnt=%0d exp 0/0", bus.rx_valid, bus.rx_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_full_rx();
    test_simultaneous();
    test_tx_backpressure();
    test_independence();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_umi_sim_queue_pair
